// File: rtl/pattern_seq_pkg.sv
// pattern_seq_pkg: shared types and helpers for the pattern sequencer buffer.
// Field offsets are functions of the tweak count, so any NUM_TWEAKS gets a consistent map.
package pattern_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    HOLD  = 2'd2
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int num_fields(input int nt);
    return 2 + 2 * (2 + nt);
  endfunction

  // N-side block (sense, delay, tweaks) starts right after the P-side block
  function automatic int F_NSENSE(input int nt);
    return 4 + nt;
  endfunction

  function automatic int F_NDELAY(input int nt);
    return F_NSENSE(nt) + 1;
  endfunction

  function automatic int F_NTWEAK0(input int nt);
    return F_NSENSE(nt) + 2;
  endfunction

  // P-side block sits exactly one phase block (2+nt fields) below the N-side block
  function automatic int F_PSENSE(input int nt);
    return F_NSENSE(nt) - (2 + nt);
  endfunction

  function automatic int F_PDELAY(input int nt);
    return F_PSENSE(nt) + 1;
  endfunction

  function automatic int F_PTWEAK0(input int nt);
    return F_PSENSE(nt) + 2;
  endfunction

  // The two main drive words precede both phase blocks
  function automatic int F_PDRIVE(input int nt);
    return F_PSENSE(nt) - 2;
  endfunction

  function automatic int F_NDRIVE(input int nt);
    return F_PSENSE(nt) - 1;
  endfunction

endpackage

// File: rtl/pattern_seq_store.sv
// pattern_seq_store: pattern storage with range-checked write port, registered read
// port and a combinational whole-buffer fetch used to drive the outputs.
module pattern_seq_store
  import pattern_seq_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int NUM_BUFS   = 8,
  parameter int NUM_TWEAKS = 4,
  parameter int NUM_FIELDS = num_fields(NUM_TWEAKS),
  parameter int BUF_W      = clog2(NUM_BUFS),
  parameter int FIELD_W    = clog2(NUM_FIELDS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_wr_en,
  input  logic [BUF_W-1:0]            i_wr_buf,
  input  logic [FIELD_W-1:0]          i_wr_field,
  input  logic [WIDTH-1:0]            i_wr_data,
  output logic                        o_wr_err,
  input  logic [BUF_W-1:0]            i_rd_buf,
  input  logic [FIELD_W-1:0]          i_rd_field,
  output logic [WIDTH-1:0]            o_rd_data,
  input  logic [BUF_W-1:0]            i_fetch_buf,
  output logic [NUM_FIELDS*WIDTH-1:0] o_fetch
);

  logic [WIDTH-1:0] r_mem [NUM_BUFS][NUM_FIELDS];
  logic [WIDTH-1:0] r_rd_data;
  logic             r_wr_err;
  logic             w_wr_ok;
  logic             w_rd_ok;

  assign w_wr_ok   = (int'(i_wr_buf) < NUM_BUFS) && (int'(i_wr_field) < NUM_FIELDS);
  assign w_rd_ok   = (int'(i_rd_buf) < NUM_BUFS) && (int'(i_rd_field) < NUM_FIELDS);
  assign o_rd_data = r_rd_data;
  assign o_wr_err  = r_wr_err;

  // Storage array: cleared on reset, in-range writes land at the clock edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BUFS; b++) begin
        for (int f = 0; f < NUM_FIELDS; f++) begin
          r_mem[b][f] <= '0;
        end
      end
    end else if (i_wr_en && w_wr_ok) begin
      r_mem[i_wr_buf][i_wr_field] <= i_wr_data;
    end
  end

  // Registered read (pre-write data on a same-cycle collision) and write-error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
      r_wr_err  <= 1'b0;
    end else begin
      r_rd_data <= w_rd_ok ? r_mem[i_rd_buf][i_rd_field] : '0;
      r_wr_err  <= i_wr_en && !w_wr_ok;
    end
  end

  // Flatten every field of the selected buffer; field f lives at [f*WIDTH +: WIDTH]
  always_comb begin
    o_fetch = '0;
    for (int f = 0; f < NUM_FIELDS; f++) begin
      o_fetch[f*WIDTH +: WIDTH] = r_mem[i_fetch_buf][f];
    end
  end

endmodule

// File: rtl/pattern_sequencer_buf.sv
// pattern_sequencer_buf: steps through NUM_BUFS pattern sets after every pwm edge,
// holding each for dwell+1 cycles, and drives registered P- or N-phase words.
// Optional macro PATSEQ_WRAP_EN: wrap back to buffer 0 after the last buffer
// instead of holding it (HOLD is then never entered).
module pattern_sequencer_buf
  import pattern_seq_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int NUM_BUFS   = 8,
  parameter int NUM_TWEAKS = 4,
  parameter int DWELL_W    = 4
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     i_pwm,
  input  logic [DWELL_W-1:0]                       i_dwell,
  input  logic                                     i_wr_en,
  input  logic [clog2(NUM_BUFS)-1:0]               i_wr_buf,
  input  logic [clog2(num_fields(NUM_TWEAKS))-1:0] i_wr_field,
  input  logic [WIDTH-1:0]                         i_wr_data,
  output logic                                     o_wr_err,
  input  logic [clog2(NUM_BUFS)-1:0]               i_rd_buf,
  input  logic [clog2(num_fields(NUM_TWEAKS))-1:0] i_rd_field,
  output logic [WIDTH-1:0]                         o_rd_data,
  output logic [WIDTH-1:0]                         o_p_drive,
  output logic [WIDTH-1:0]                         o_n_drive,
  output logic [WIDTH-1:0]                         o_tweak_sense,
  output logic [WIDTH-1:0]                         o_tweak_delay,
  output logic [NUM_TWEAKS*WIDTH-1:0]              o_tweak_drive,
  output logic [clog2(NUM_BUFS)-1:0]               o_buf_sel,
  output logic                                     o_sweep_done
);

  localparam int NUM_FIELDS = num_fields(NUM_TWEAKS);
  localparam int BUF_W      = clog2(NUM_BUFS);
  localparam int FIELD_W    = clog2(NUM_FIELDS);
  localparam int TW_W       = NUM_TWEAKS * WIDTH;
  localparam logic [BUF_W-1:0] LAST_BUF = BUF_W'(NUM_BUFS - 1);

  localparam int O_PDRIVE  = F_PDRIVE(NUM_TWEAKS)  * WIDTH;
  localparam int O_NDRIVE  = F_NDRIVE(NUM_TWEAKS)  * WIDTH;
  localparam int O_PSENSE  = F_PSENSE(NUM_TWEAKS)  * WIDTH;
  localparam int O_PDELAY  = F_PDELAY(NUM_TWEAKS)  * WIDTH;
  localparam int O_PTWEAK0 = F_PTWEAK0(NUM_TWEAKS) * WIDTH;
  localparam int O_NSENSE  = F_NSENSE(NUM_TWEAKS)  * WIDTH;
  localparam int O_NDELAY  = F_NDELAY(NUM_TWEAKS)  * WIDTH;
  localparam int O_NTWEAK0 = F_NTWEAK0(NUM_TWEAKS) * WIDTH;

  state_e                      r_state;
  state_e                      w_state_nxt;
  logic [BUF_W-1:0]            r_buf_sel;
  logic [BUF_W-1:0]            w_buf_sel_nxt;
  logic [DWELL_W-1:0]          r_dwell_cnt;
  logic [DWELL_W-1:0]          w_dwell_cnt_nxt;
  logic [DWELL_W-1:0]          r_dwell;
  logic                        r_pwm_prev;
  logic                        w_edge;
  logic                        w_active;
  logic [NUM_FIELDS*WIDTH-1:0] w_fetch;

  logic [WIDTH-1:0]            r_p_drive;
  logic [WIDTH-1:0]            r_n_drive;
  logic [WIDTH-1:0]            r_tweak_sense;
  logic [WIDTH-1:0]            r_tweak_delay;
  logic [TW_W-1:0]             r_tweak_drive;

  assign w_edge   = (i_pwm != r_pwm_prev);
  assign w_active = (r_state == SWEEP) || (r_state == HOLD);

  assign o_p_drive     = r_p_drive;
  assign o_n_drive     = r_n_drive;
  assign o_tweak_sense = r_tweak_sense;
  assign o_tweak_delay = r_tweak_delay;
  assign o_tweak_drive = r_tweak_drive;
  assign o_buf_sel     = r_buf_sel;
  assign o_sweep_done  = (r_state == HOLD);

  pattern_seq_store #(
    .WIDTH      (WIDTH),
    .NUM_BUFS   (NUM_BUFS),
    .NUM_TWEAKS (NUM_TWEAKS),
    .NUM_FIELDS (NUM_FIELDS),
    .BUF_W      (BUF_W),
    .FIELD_W    (FIELD_W)
  ) u_store (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_wr_en     (i_wr_en),
    .i_wr_buf    (i_wr_buf),
    .i_wr_field  (i_wr_field),
    .i_wr_data   (i_wr_data),
    .o_wr_err    (o_wr_err),
    .i_rd_buf    (i_rd_buf),
    .i_rd_field  (i_rd_field),
    .o_rd_data   (o_rd_data),
    .i_fetch_buf (r_buf_sel),
    .o_fetch     (w_fetch)
  );

  // Sequencer state, pwm history and the dwell value captured at each edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_buf_sel   <= '0;
      r_dwell_cnt <= '0;
      r_dwell     <= '0;
      r_pwm_prev  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_buf_sel   <= w_buf_sel_nxt;
      r_dwell_cnt <= w_dwell_cnt_nxt;
      r_pwm_prev  <= i_pwm;
      if (w_edge) r_dwell <= i_dwell;
    end
  end

  // Next-state: a pwm edge always restarts the sweep, otherwise count down and advance
  always_comb begin
    w_state_nxt     = r_state;
    w_buf_sel_nxt   = r_buf_sel;
    w_dwell_cnt_nxt = r_dwell_cnt;
    if (w_edge) begin
      w_state_nxt     = SWEEP;
      w_buf_sel_nxt   = '0;
      w_dwell_cnt_nxt = i_dwell;
    end else begin
      case (r_state)
        SWEEP: begin
          if (r_dwell_cnt != '0) begin
            w_dwell_cnt_nxt = r_dwell_cnt - DWELL_W'(1);
          end else if (r_buf_sel < LAST_BUF) begin
            w_buf_sel_nxt   = r_buf_sel + BUF_W'(1);
            w_dwell_cnt_nxt = r_dwell;
          end else begin
`ifdef PATSEQ_WRAP_EN
            w_buf_sel_nxt   = '0;
            w_dwell_cnt_nxt = r_dwell;
`else
            w_state_nxt     = HOLD;
`endif
          end
        end
        IDLE, HOLD: begin
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // Driver words: registered from the buffer being driven this cycle and the current phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p_drive     <= '1;
      r_n_drive     <= '0;
      r_tweak_sense <= '0;
      r_tweak_delay <= '0;
      r_tweak_drive <= '0;
    end else if (!w_active) begin
      r_p_drive     <= '1;
      r_n_drive     <= '0;
      r_tweak_sense <= '0;
      r_tweak_delay <= '0;
      r_tweak_drive <= '0;
    end else if (r_pwm_prev) begin
      r_p_drive     <= w_fetch[O_PDRIVE +: WIDTH];
      r_n_drive     <= '0;
      r_tweak_sense <= w_fetch[O_PSENSE +: WIDTH];
      r_tweak_delay <= w_fetch[O_PDELAY +: WIDTH];
      r_tweak_drive <= w_fetch[O_PTWEAK0 +: TW_W];
    end else begin
      r_p_drive     <= '1;
      r_n_drive     <= w_fetch[O_NDRIVE +: WIDTH];
      r_tweak_sense <= w_fetch[O_NSENSE +: WIDTH];
      r_tweak_delay <= w_fetch[O_NDELAY +: WIDTH];
      r_tweak_drive <= w_fetch[O_NTWEAK0 +: TW_W];
    end
  end

endmodule

// File: tb/tb_pattern_sequencer_buf.sv
// tb_pattern_sequencer_buf: directed stimulus pushes cycle-tagged expectations into a
// scoreboard queue; a negedge monitor pops and compares them when their cycle comes up.
module tb_pattern_sequencer_buf;

  localparam int WIDTH      = 8;
  localparam int NUM_BUFS   = 8;
  localparam int NUM_TWEAKS = 4;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        pwm = 1'b0;
  logic [3:0]  dwell = '0;
  logic        wrEn = 1'b0;
  logic [2:0]  wrBuf = '0;
  logic [3:0]  wrField = '0;
  logic [7:0]  wrData = '0;
  logic        wrErr;
  logic [2:0]  rdBuf = '0;
  logic [3:0]  rdField = '0;
  logic [7:0]  rdData;
  logic [7:0]  pDrive;
  logic [7:0]  nDrive;
  logic [7:0]  tweakSense;
  logic [7:0]  tweakDelay;
  logic [31:0] tweakDrive;
  logic [2:0]  bufSel;
  logic        sweepDone;

  typedef enum int {S_P, S_N, S_SENSE, S_DELAY, S_TWEAK, S_BUF, S_DONE, S_RD, S_ERR} sig_e;
  typedef struct {
    int          due;
    sig_e        sig;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  pattern_sequencer_buf #(
    .WIDTH      (WIDTH),
    .NUM_BUFS   (NUM_BUFS),
    .NUM_TWEAKS (NUM_TWEAKS),
    .DWELL_W    (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rstN),
    .i_pwm         (pwm),
    .i_dwell       (dwell),
    .i_wr_en       (wrEn),
    .i_wr_buf      (wrBuf),
    .i_wr_field    (wrField),
    .i_wr_data     (wrData),
    .o_wr_err      (wrErr),
    .i_rd_buf      (rdBuf),
    .i_rd_field    (rdField),
    .o_rd_data     (rdData),
    .o_p_drive     (pDrive),
    .o_n_drive     (nDrive),
    .o_tweak_sense (tweakSense),
    .o_tweak_delay (tweakDelay),
    .o_tweak_drive (tweakDrive),
    .o_buf_sel     (bufSel),
    .o_sweep_done  (sweepDone)
  );

  // Free-running clock and a cycle counter that tags every expectation
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Buffer index expected k steps into a sweep, with or without wrap-around
  function automatic int expBuf(input int k);
`ifdef PATSEQ_WRAP_EN
    return k % NUM_BUFS;
`else
    return (k > NUM_BUFS - 1) ? NUM_BUFS - 1 : k;
`endif
  endfunction

  task automatic expectAt(input sig_e s, input int off, input logic [31:0] v);
    exp_t e;
    e.due = cyc + off;
    e.sig = s;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input sig_e s, input logic [31:0] exp, input int at);
    logic [31:0] act;
    case (s)
      S_P:     act = {24'h0, pDrive};
      S_N:     act = {24'h0, nDrive};
      S_SENSE: act = {24'h0, tweakSense};
      S_DELAY: act = {24'h0, tweakDelay};
      S_TWEAK: act = tweakDrive;
      S_BUF:   act = {29'h0, bufSel};
      S_DONE:  act = {31'h0, sweepDone};
      S_RD:    act = {24'h0, rdData};
      default: act = {31'h0, wrErr};
    endcase
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s @cyc %0d: got %h, want %h", s.name(), at, act, exp);
    end
  endtask

  // Monitor: compare every expectation due this cycle, flag any that slipped past
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        checkOutput(sb[i].sig, sb[i].exp, cyc);
        sb.delete(i);
      end else if (sb[i].due < cyc) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL %s missed @cyc %0d: got none, want %h", sb[i].sig.name(), sb[i].due, sb[i].exp);
        sb.delete(i);
      end
    end
  end

  task automatic applyStimulus(input logic we, input logic [2:0] wb, input logic [3:0] wf,
                               input logic [7:0] wd, input logic [2:0] rb, input logic [3:0] rf);
    @(negedge clk);
    wrEn    = we;
    wrBuf   = wb;
    wrField = wf;
    wrData  = wd;
    rdBuf   = rb;
    rdField = rf;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset and initial state
    waitCycles(3);
    rstN = 1'b1;
    expectAt(S_P, 1, 32'hFF);
    expectAt(S_N, 1, 32'h00);
    expectAt(S_TWEAK, 1, 32'h0);
    expectAt(S_BUF, 1, 32'h0);
    expectAt(S_DONE, 1, 32'h0);
    expectAt(S_RD, 1, 32'h0);
    expectAt(S_ERR, 1, 32'h0);

    // Load patterns
    for (int b = 0; b < NUM_BUFS; b++) begin
      applyStimulus(1'b1, 3'(b), 4'd0, 8'(8'h10 + b), 3'd0, 4'd0);
      applyStimulus(1'b1, 3'(b), 4'd1, 8'(8'h20 + b), 3'd0, 4'd0);
      applyStimulus(1'b1, 3'(b), 4'd2, 8'(8'h30 + b), 3'd0, 4'd0);
      applyStimulus(1'b1, 3'(b), 4'd9, 8'(8'h50 + b), 3'd0, 4'd0);
    end
    applyStimulus(1'b1, 3'd0, 4'd5, 8'h61, 3'd0, 4'd0);
    applyStimulus(1'b1, 3'd0, 4'd13, 8'h73, 3'd0, 4'd0);
    applyStimulus(1'b1, 3'd3, 4'd13, 8'h5A, 3'd0, 4'd0);
    applyStimulus(1'b0, 3'd0, 4'd0, 8'h00, 3'd2, 4'd1);
    expectAt(S_RD, 1, 32'h22);
    expectAt(S_P, 1, 32'hFF);
    expectAt(S_N, 1, 32'h00);
    expectAt(S_ERR, 1, 32'h0);

    // P sweep with dwell 0
    @(negedge clk);
    dwell = 4'd0;
    pwm   = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      expectAt(S_P, 2 + k, 32'(8'h10 + expBuf(k)));
      expectAt(S_N, 2 + k, 32'h00);
    end
    for (int k = 0; k <= 11; k++) begin
      expectAt(S_BUF, 1 + k, 32'(expBuf(k)));
    end
    expectAt(S_SENSE, 2, 32'h30);
    expectAt(S_DELAY, 2, 32'h00);
    expectAt(S_TWEAK, 2, 32'h0000_6100);
`ifdef PATSEQ_WRAP_EN
    expectAt(S_DONE, 9, 32'h0);
    expectAt(S_DONE, 12, 32'h0);
`else
    expectAt(S_DONE, 8, 32'h0);
    expectAt(S_DONE, 9, 32'h1);
    expectAt(S_DONE, 12, 32'h1);
`endif
    waitCycles(13);

    // N sweep with dwell 2: each buffer held three cycles
    dwell = 4'd2;
    pwm   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 3; j++) begin
        expectAt(S_N, 2 + 3 * k + j, 32'(8'h20 + k));
        expectAt(S_P, 2 + 3 * k + j, 32'hFF);
      end
    end
    expectAt(S_SENSE, 2, 32'h00);
    expectAt(S_DELAY, 2, 32'h50);
    expectAt(S_TWEAK, 2, 32'h7300_0000);
    expectAt(S_BUF, 1, 32'h0);
    expectAt(S_BUF, 4, 32'h1);
    expectAt(S_BUF, 16, 32'h5);
    expectAt(S_DONE, 16, 32'h0);
    waitCycles(16);

    // Edge in the middle of the sweep abandons it and restarts at buffer 0
    pwm = 1'b1;
    expectAt(S_BUF, 1, 32'h0);
    expectAt(S_N, 1, 32'h25);
    expectAt(S_P, 2, 32'h10);
    expectAt(S_N, 2, 32'h00);
    expectAt(S_SENSE, 2, 32'h30);
    expectAt(S_BUF, 4, 32'h1);
    expectAt(S_P, 5, 32'h11);

    // Out-of-range write, then write/read collision on the same location
    applyStimulus(1'b1, 3'd0, 4'd14, 8'hEE, 3'd0, 4'd0);
    expectAt(S_ERR, 1, 32'h1);
    applyStimulus(1'b1, 3'd3, 4'd13, 8'hA5, 3'd3, 4'd13);
    expectAt(S_ERR, 1, 32'h0);
    expectAt(S_RD, 1, 32'h5A);
    applyStimulus(1'b0, 3'd0, 4'd0, 8'h00, 3'd3, 4'd13);
    expectAt(S_RD, 1, 32'hA5);
    applyStimulus(1'b0, 3'd0, 4'd0, 8'h00, 3'd0, 4'd0);
    expectAt(S_RD, 1, 32'h10);
    applyStimulus(1'b0, 3'd0, 4'd0, 8'h00, 3'd0, 4'd6);
    expectAt(S_RD, 1, 32'h00);
    applyStimulus(1'b0, 3'd0, 4'd0, 8'h00, 3'd0, 4'd15);
    expectAt(S_RD, 1, 32'h00);

    // Asynchronous reset mid-sweep: drivers off before the next clock edge
    @(posedge clk);
    #2;
    rstN = 1'b0;
    pwm  = 1'b0;
    expectAt(S_P, 0, 32'hFF);
    expectAt(S_N, 0, 32'h00);
    expectAt(S_SENSE, 0, 32'h00);
    expectAt(S_TWEAK, 0, 32'h0);
    expectAt(S_BUF, 0, 32'h0);
    expectAt(S_DONE, 0, 32'h0);
    waitCycles(3);
    rstN    = 1'b1;
    rdBuf   = 3'd0;
    rdField = 4'd0;
    expectAt(S_RD, 1, 32'h00);
    for (int k = 1; k <= 4; k++) begin
      expectAt(S_P, k, 32'hFF);
      expectAt(S_N, k, 32'h00);
      expectAt(S_BUF, k, 32'h0);
    end

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
    while (sb.size() > 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s pending @cyc %0d: got none, want %h", sb[0].sig.name(), sb[0].due, sb[0].exp);
      void'(sb.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
